// File: rtl/sp_bram_bank.sv
// Single-port byte-enabled block RAM bank with valid/ready request side and fixed-latency responses.
// Define SP_BRAM_BANK_INIT_CLEAR_EN to zero the whole array after reset before entering service.
module sp_bram_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SETS   = 1024,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                        clk,
    input  logic                        rst_ni,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [$clog2(NUM_SETS)-1:0] req_addr_i,
    input  logic                        req_wr_i,
    input  logic [DATA_WIDTH/8-1:0]     req_be_i,
    input  logic [DATA_WIDTH-1:0]       req_wdata_i,
    output logic                        rsp_valid_o,
    output logic [DATA_WIDTH-1:0]       rsp_rdata_o,
    output logic                        init_done_o
);
    localparam int AW = $clog2(NUM_SETS);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic {
        INIT  = 1'b0,
        SERVE = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem [NUM_SETS];
    logic                  accept;
    logic                  nochg;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged;
    logic                  valid1_q, valid1_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    assign accept      = req_valid_i && (state_q == SERVE);
    assign nochg       = accept && req_wr_i && (RDW_MODE == 2);
    assign req_ready_o = (state_q == SERVE);
    assign init_done_o = (state_q == SERVE);
    assign old_word    = mem[req_addr_i];

`ifdef SP_BRAM_BANK_INIT_CLEAR_EN
    logic [AW-1:0] cnt_q, cnt_d;

    // Counter saturates on the last address so SERVE can never fall back.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            if (cnt_q == AW'(NUM_SETS - 1)) begin
                state_d = SERVE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        state_d = state_q;
        if (state_q == INIT) begin
            state_d = SERVE;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        merged = old_word;
        for (int b = 0; b < NB; b++) begin
            if (req_be_i[b]) begin
                merged[8*b +: 8] = req_wdata_i[8*b +: 8];
            end
        end
    end

    // Array is deliberately left out of reset.
    always_ff @(posedge clk) begin
`ifdef SP_BRAM_BANK_INIT_CLEAR_EN
        if (state_q == INIT) begin
            mem[cnt_q] <= '0;
        end
`endif
        if (accept && req_wr_i) begin
            for (int b = 0; b < NB; b++) begin
                if (req_be_i[b]) begin
                    mem[req_addr_i][8*b +: 8] <= req_wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        valid1_d = accept;
        rdata1_d = rdata1_q;
        if (accept && !nochg) begin
            rdata1_d = (!req_wr_i || RDW_MODE == 1) ? old_word : merged;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            valid1_q <= 1'b0;
            rdata1_q <= '0;
        end else begin
            valid1_q <= valid1_d;
            rdata1_q <= rdata1_d;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  valid2_q;
            logic                  hold1_q;
            logic [DATA_WIDTH-1:0] rdata2_q, rdata2_d;

            // A no-change write must not disturb the visible output word.
            assign rdata2_d = (valid1_q && !hold1_q) ? rdata1_q : rdata2_q;

            always_ff @(posedge clk or negedge rst_ni) begin
                if (!rst_ni) begin
                    valid2_q <= 1'b0;
                    hold1_q  <= 1'b0;
                    rdata2_q <= '0;
                end else begin
                    valid2_q <= valid1_q;
                    hold1_q  <= nochg;
                    rdata2_q <= rdata2_d;
                end
            end

            assign rsp_valid_o = valid2_q;
            assign rsp_rdata_o = rdata2_q;
        end else begin : g_lat1
            assign rsp_valid_o = valid1_q;
            assign rsp_rdata_o = rdata1_q;
        end
    endgenerate

endmodule

// File: tb/tb_sp_bram_bank.sv
// Directed bench for sp_bram_bank: three instances covering write-first,
// read-first with two-cycle latency, and no-change read-during-write.
module tb_sp_bram_bank;
    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic [3:0]  req_addr = '0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  rdy, vld, done;
    logic [31:0] rd0, rd1, rd2;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] d2_last;

    always #5 clk = ~clk;

    sp_bram_bank #(.DATA_WIDTH(32), .NUM_SETS(16), .RD_LATENCY(1), .RDW_MODE(0)) u_d0 (
        .clk(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(rdy[0]),
        .req_addr_i(req_addr), .req_wr_i(req_wr), .req_be_i(req_be), .req_wdata_i(req_wdata),
        .rsp_valid_o(vld[0]), .rsp_rdata_o(rd0), .init_done_o(done[0]));

    sp_bram_bank #(.DATA_WIDTH(32), .NUM_SETS(16), .RD_LATENCY(2), .RDW_MODE(1)) u_d1 (
        .clk(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(rdy[1]),
        .req_addr_i(req_addr), .req_wr_i(req_wr), .req_be_i(req_be), .req_wdata_i(req_wdata),
        .rsp_valid_o(vld[1]), .rsp_rdata_o(rd1), .init_done_o(done[1]));

    sp_bram_bank #(.DATA_WIDTH(32), .NUM_SETS(16), .RD_LATENCY(1), .RDW_MODE(2)) u_d2 (
        .clk(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(rdy[2]),
        .req_addr_i(req_addr), .req_wr_i(req_wr), .req_be_i(req_be), .req_wdata_i(req_wdata),
        .rsp_valid_o(vld[2]), .rsp_rdata_o(rd2), .init_done_o(done[2]));

    function automatic logic [31:0] pat(input int i);
        return 32'hB000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    task automatic drive(input logic v, input logic wr, input logic [3:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        req_valid = v;
        req_wr    = wr;
        req_addr  = a;
        req_be    = be;
        req_wdata = wd;
    endtask

    task automatic xact(input logic wr, input logic [3:0] a, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] r0, output logic [31:0] r1,
                        output logic [31:0] r2, output logic [2:0] v);
        drive(1'b1, wr, a, be, wd);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        r0   = rd0;
        r2   = rd2;
        v[0] = vld[0];
        v[2] = vld[2];
        @(posedge clk); #1;
        r1   = rd1;
        v[1] = vld[1];
    endtask

    task automatic wait_ready(output int n, output logic bad_v);
        n     = 0;
        bad_v = 1'b0;
        while (rdy[0] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (vld !== 3'b000) bad_v = 1'b1;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        drive(1'b1, 1'b0, 4'd5, 4'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (rdy !== 3'b000) begin n_fail++; $display("FAIL reset_ready got %b want 000", rdy); end
        n_tests++;
        if (vld !== 3'b000) begin n_fail++; $display("FAIL reset_valid got %b want 000", vld); end
        n_tests++;
        if (done !== 3'b000) begin n_fail++; $display("FAIL reset_done got %b want 000", done); end
        n_tests++;
        if ({rd0, rd1, rd2} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_rdata got %h %h %h want 0", rd0, rd1, rd2);
        end
    endtask

    task automatic test_init;
        int          n;
        int          exp_n;
        logic        bad_v;
        logic [31:0] r0, r1, r2;
        logic [2:0]  v;
`ifdef SP_BRAM_BANK_INIT_CLEAR_EN
        exp_n = 16;
`else
        exp_n = 1;
`endif
        rst_ni = 1'b1;
        wait_ready(n, bad_v);
        n_tests++;
        if (n != exp_n) begin n_fail++; $display("FAIL init_cycles got %0d want %0d", n, exp_n); end
        n_tests++;
        if (rdy !== 3'b111 || done !== 3'b111) begin
            n_fail++;
            $display("FAIL init_flags got rdy=%b done=%b want 111", rdy, done);
        end
        n_tests++;
        if (bad_v !== 1'b0) begin n_fail++; $display("FAIL init_no_rsp got %b want 0", bad_v); end
        d2_last = 32'd0;
`ifdef SP_BRAM_BANK_INIT_CLEAR_EN
        xact(1'b0, 4'd5, 4'd0, 32'd0, r0, r1, r2, v);
        n_tests++;
        if (v !== 3'b111) begin n_fail++; $display("FAIL init_read_valid got %b want 111", v); end
        n_tests++;
        if ({r0, r1, r2} !== 96'd0) begin
            n_fail++;
            $display("FAIL init_read_zero got %h %h %h want 0", r0, r1, r2);
        end
`endif
    endtask

    task automatic test_byte_enable;
        logic [31:0] r0, r1, r2;
        logic [2:0]  v;
        xact(1'b1, 4'd3, 4'hF, 32'hDEAD_BEEF, r0, r1, r2, v);
        n_tests++;
        if (v !== 3'b111) begin n_fail++; $display("FAIL be_full_valid got %b want 111", v); end
        n_tests++;
        if (r0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL be_full_wf got %h want deadbeef", r0); end
        n_tests++;
        if (r2 !== d2_last) begin n_fail++; $display("FAIL be_full_nc got %h want %h", r2, d2_last); end
        xact(1'b1, 4'd3, 4'b0101, 32'h1122_3344, r0, r1, r2, v);
        n_tests++;
        if (r0 !== 32'hDE22_BE44) begin n_fail++; $display("FAIL be_part_wf got %h want de22be44", r0); end
        n_tests++;
        if (r1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL be_part_rf got %h want deadbeef", r1); end
        n_tests++;
        if (r2 !== d2_last) begin n_fail++; $display("FAIL be_part_nc got %h want %h", r2, d2_last); end
        xact(1'b1, 4'd3, 4'b0000, 32'hFFFF_FFFF, r0, r1, r2, v);
        n_tests++;
        if (v !== 3'b111) begin n_fail++; $display("FAIL be_zero_valid got %b want 111", v); end
        n_tests++;
        if (r0 !== 32'hDE22_BE44) begin n_fail++; $display("FAIL be_zero_wf got %h want de22be44", r0); end
        xact(1'b0, 4'd3, 4'd0, 32'd0, r0, r1, r2, v);
        n_tests++;
        if (r0 !== 32'hDE22_BE44 || r1 !== 32'hDE22_BE44 || r2 !== 32'hDE22_BE44) begin
            n_fail++;
            $display("FAIL be_readback got %h %h %h want de22be44", r0, r1, r2);
        end
        d2_last = 32'hDE22_BE44;
    endtask

    task automatic test_rdw;
        logic [31:0] r0, r1, r2;
        logic [2:0]  v;
        xact(1'b1, 4'd7, 4'hF, 32'hAAAA_AAAA, r0, r1, r2, v);
        xact(1'b1, 4'd7, 4'hF, 32'h5555_5555, r0, r1, r2, v);
        n_tests++;
        if (r0 !== 32'h5555_5555) begin n_fail++; $display("FAIL rdw_write_first got %h want 55555555", r0); end
        n_tests++;
        if (r1 !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL rdw_read_first got %h want aaaaaaaa", r1); end
        n_tests++;
        if (r2 !== d2_last) begin n_fail++; $display("FAIL rdw_no_change got %h want %h", r2, d2_last); end
        xact(1'b0, 4'd7, 4'd0, 32'd0, r0, r1, r2, v);
        n_tests++;
        if (r0 !== 32'h5555_5555 || r1 !== 32'h5555_5555 || r2 !== 32'h5555_5555) begin
            n_fail++;
            $display("FAIL rdw_readback got %h %h %h want 55555555", r0, r1, r2);
        end
        d2_last = 32'h5555_5555;
    endtask

    task automatic test_back_to_back;
        logic stall;
        stall = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 4'(i), 4'hF, pat(i));
            @(posedge clk); #1;
            if (rdy !== 3'b111) stall = 1'b1;
        end
        drive(1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_ready got stall=%b want 0", stall); end
        for (int k = 0; k < 18; k++) begin
            if (k < 16) drive(1'b1, 1'b0, 4'(k), 4'd0, 32'd0);
            else drive(1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
            @(posedge clk); #1;
            if (k < 16) begin
                n_tests++;
                if (vld[0] !== 1'b1 || rd0 !== pat(k)) begin
                    n_fail++;
                    $display("FAIL b2b_lat1[%0d] got v=%b %h want v=1 %h", k, vld[0], rd0, pat(k));
                end
            end
            if (k == 0 || k == 17) begin
                n_tests++;
                if (vld[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_lat2_edge[%0d] got v=%b want 0", k, vld[1]);
                end
            end else begin
                n_tests++;
                if (vld[1] !== 1'b1 || rd1 !== pat(k - 1)) begin
                    n_fail++;
                    $display("FAIL b2b_lat2[%0d] got v=%b %h want v=1 %h", k - 1, vld[1], rd1, pat(k - 1));
                end
            end
        end
        d2_last = pat(15);
    endtask

    task automatic test_reset_mid;
        int   n;
        int   exp_n;
        logic bad_v;
`ifdef SP_BRAM_BANK_INIT_CLEAR_EN
        exp_n = 16;
`else
        exp_n = 1;
`endif
        drive(1'b1, 1'b0, 4'd3, 4'd0, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        n_tests++;
        if (vld[0] !== 1'b1) begin n_fail++; $display("FAIL mid_accept got %b want 1", vld[0]); end
        rst_ni = 1'b0;
        #1;
        bad_v = (vld !== 3'b000);
        repeat (3) begin
            @(posedge clk); #1;
            if (vld !== 3'b000) bad_v = 1'b1;
        end
        n_tests++;
        if (bad_v !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_drop got %b want 0", bad_v); end
        rst_ni = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        rst_ni = 1'b0;
        #1;
        n_tests++;
        if (rdy !== 3'b000 || vld !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_init_reset got rdy=%b vld=%b want 000", rdy, vld);
        end
        @(posedge clk); #1;
        rst_ni = 1'b1;
        wait_ready(n, bad_v);
        n_tests++;
        if (n != exp_n) begin n_fail++; $display("FAIL mid_restart got %0d want %0d", n, exp_n); end
        n_tests++;
        if (bad_v !== 1'b0) begin n_fail++; $display("FAIL mid_restart_rsp got %b want 0", bad_v); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_byte_enable();
        test_rdw();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sp_bram_bank.md
SP_BRAM_BANK -- requirements
Module: sp_bram_bank

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, word width in bits; a multiple of 8.
REQ-002 The block SHALL have parameter NUM_SETS, default 1024, word count; a power of two, at least 2.
REQ-003 The block SHALL have parameter RD_LATENCY, default 1, accept-to-response cycles; legal values 1 or 2.
REQ-004 The block SHALL have parameter RDW_MODE, default 0, read-during-write return: 0 write-first (new word), 1 read-first (old word), 2 no-change (rsp_rdata_o holds its previous value).
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock, rising-edge.
REQ-006 The block SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port req_valid_i, input, 1 bit, request present.
REQ-008 The block SHALL have port req_ready_o, output, 1 bit, block can accept a request.
REQ-009 The block SHALL have port req_addr_i, input, $clog2(NUM_SETS) bits, word address.
REQ-010 The block SHALL have port req_wr_i, input, 1 bit, 1 = write, 0 = read.
REQ-011 The block SHALL have port req_be_i, input, DATA_WIDTH/8 bits, byte write enables.
REQ-012 The block SHALL have port req_wdata_i, input, DATA_WIDTH bits, write data.
REQ-013 The block SHALL have port rsp_valid_o, output, 1 bit, response strobe, one cycle per accepted request.
REQ-014 The block SHALL have port rsp_rdata_o, output, DATA_WIDTH bits, response data.
REQ-015 The block SHALL have port init_done_o, output, 1 bit, memory initialised and in service.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid_i and req_ready_o are both 1; nothing else changes the memory.
REQ-017 A write SHALL update only the bytes whose req_be_i bit is 1; a write with req_be_i all zero SHALL leave the word unchanged and still return a response.
REQ-018 Every accepted request SHALL assert rsp_valid_o for exactly one cycle, RD_LATENCY cycles after acceptance; there is no response backpressure.
REQ-019 A read SHALL return the word as stored before any write accepted in the same or later cycles.
REQ-020 A write response SHALL carry data per RDW_MODE; with RDW_MODE 0 and partial byte enables it SHALL return the merged word.
REQ-021 With RD_LATENCY 2, rsp_rdata_o SHALL come from an output register stage; back-to-back requests SHALL be accepted every cycle, with full throughput.
REQ-022 The FSM SHALL have states INIT and SERVE; req_ready_o SHALL be 1 only in SERVE, and init_done_o SHALL equal (state == SERVE).
REQ-023 In INIT the block SHALL write zero to address 0, 1, ... NUM_SETS-1, one per cycle, using an address counter, then enter SERVE on the cycle after the last address is written; no rsp_valid_o pulses SHALL occur in INIT.
REQ-024 SERVE SHALL be held until reset; the counter SHALL NOT wrap back into INIT.

Reset
REQ-025 While rst_ni is 0, the outputs SHALL be: req_ready_o 0, rsp_valid_o 0, rsp_rdata_o 0, init_done_o 0; the FSM SHALL be in INIT with counter 0 and all pipeline valids cleared.
REQ-026 Reset assertion mid-INIT or mid-response SHALL drop in-flight responses and restart initialisation from address 0 after release.
REQ-027 The memory array itself SHALL NOT be reset; only control and output registers are.

Configuration
REQ-028 With macro SP_BRAM_BANK_INIT_CLEAR_EN defined, INIT SHALL behave per REQ-023 (NUM_SETS cycles before init_done_o rises).
REQ-029 Without SP_BRAM_BANK_INIT_CLEAR_EN, the block SHALL enter SERVE on the first rising edge after reset release, contents SHALL be undefined until written, and no clear logic SHALL be built.

Verification (NUM_SETS=16, DATA_WIDTH=32, macro defined unless stated)
REQ-030 Release reset, hold req_valid_i=1 -> init_done_o and req_ready_o rise exactly 16 cycles later; a read of addr 5 returns 0x00000000.
REQ-031 Write 0xDEADBEEF to addr 3 with be=4'b1111, then write 0x11223344 to addr 3 with be=4'b0101, then read addr 3 -> 0xDE22BE44.
REQ-032 For RD_LATENCY=2, issue reads of addr 0..15 back-to-back -> 16 consecutive rsp_valid_o pulses, the first 2 cycles after the first acceptance, with data in order.
REQ-033 With addr 7 holding 0xAAAAAAAA, write 0x55555555 to addr 7 with be=4'b1111 under RDW_MODE 0/1/2 -> response 0x55555555 / 0xAAAAAAAA / previous rsp_rdata_o.
REQ-034 Assert rst_ni=0 at INIT address 9, then release -> the clear restarts at 0 and init_done_o rises 16 cycles after release; pending responses never appear.
REQ-035 With the macro undefined -> req_ready_o is 1 on the first edge after reset release.
